// File: rtl/muldiv_ctrl.sv
// muldiv_ctrl: owns the architectural HI/LO registers of the MIPS
// multiply/divide unit. Products complete in one cycle; divides are handed
// to an external iterative divider and the pipeline is stalled until the
// quotient/remainder come back or the wait times out.
module muldiv_ctrl #(
   parameter int DIV_TIMEOUT = 64
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        op_valid,
   input  logic [2:0]  op_code,
   input  logic [31:0] op_a,
   input  logic [31:0] op_b,
   input  logic        rd_req,
   output logic [31:0] hi_out,
   output logic [31:0] lo_out,
   output logic        busy,
   output logic        stall,
   output logic        div_err,
   output logic [31:0] div_a,
   output logic [31:0] div_b,
   output logic        div_signed,
   output logic        div_rst,
   input  logic        div_done,
   input  logic [31:0] div_q,
   input  logic [31:0] div_r
);

   localparam int CNT_W = $clog2(DIV_TIMEOUT + 1);

   localparam logic [2:0] OP_MULT  = 3'b001;
   localparam logic [2:0] OP_MULTU = 3'b010;
   localparam logic [2:0] OP_DIV   = 3'b011;
   localparam logic [2:0] OP_DIVU  = 3'b100;
   localparam logic [2:0] OP_MTHI  = 3'b101;
   localparam logic [2:0] OP_MTLO  = 3'b110;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_LAUNCH = 2'd1,
      ST_WAIT   = 2'd2
   } state_t;

   state_t             state_q;
   logic [31:0]        hi_q;
   logic [31:0]        lo_q;
   logic [31:0]        div_a_q;
   logic [31:0]        div_b_q;
   logic               div_signed_q;
   logic               div_err_q;
   logic [CNT_W-1:0]   wait_cnt_q;

   logic               accept_s;
   logic [63:0]        prod_signed_s;
   logic [63:0]        prod_unsigned_s;

   // Request acceptance and both one-cycle products (sign-extended to 64 bits
   // so the signed product needs no truncation beyond the low 64 bits).
   always_comb begin
      accept_s        = op_valid && (state_q == ST_IDLE);
      prod_signed_s   = $signed({{32{op_a[31]}}, op_a}) * $signed({{32{op_b[31]}}, op_b});
      prod_unsigned_s = {32'd0, op_a} * {32'd0, op_b};
   end

   // Main controller: decodes accepted ops, sequences the divider, writes HI/LO.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= ST_IDLE;
         hi_q         <= 32'd0;
         lo_q         <= 32'd0;
         div_a_q      <= 32'd0;
         div_b_q      <= 32'd0;
         div_signed_q <= 1'b0;
         div_err_q    <= 1'b0;
         wait_cnt_q   <= '0;
      end else begin
         case (state_q)
            ST_IDLE: begin
               if (accept_s) begin
                  div_err_q <= 1'b0;
                  case (op_code)
                     OP_MULT:  {hi_q, lo_q} <= prod_signed_s;
                     OP_MULTU: {hi_q, lo_q} <= prod_unsigned_s;
                     OP_DIV, OP_DIVU: begin
                        if (op_b == 32'd0) begin
                           // Divide by zero never reaches the divider.
                           hi_q <= op_a;
                           lo_q <= 32'hFFFF_FFFF;
                        end else begin
                           div_a_q      <= op_a;
                           div_b_q      <= op_b;
                           div_signed_q <= (op_code == OP_DIV);
                           state_q      <= ST_LAUNCH;
                        end
                     end
                     OP_MTHI:  hi_q <= op_a;
                     OP_MTLO:  lo_q <= op_a;
                     default:  ;
                  endcase
               end else begin
                  state_q <= ST_IDLE;
               end
            end
            ST_LAUNCH: begin
               // div_rst is high this cycle; the wait budget starts fresh.
               wait_cnt_q <= '0;
               state_q    <= ST_WAIT;
            end
            ST_WAIT: begin
               if (div_done) begin
                  lo_q    <= div_q;
                  hi_q    <= div_r;
                  state_q <= ST_IDLE;
               end else if (wait_cnt_q == CNT_W'(DIV_TIMEOUT - 1)) begin
                  div_err_q <= 1'b1;
                  state_q   <= ST_IDLE;
               end else begin
                  wait_cnt_q <= wait_cnt_q + CNT_W'(1);
               end
            end
            default: state_q <= ST_IDLE;
         endcase
      end
   end

   assign hi_out     = hi_q;
   assign lo_out     = lo_q;
   assign busy       = (state_q != ST_IDLE);
   assign stall      = busy & (op_valid | rd_req);
   assign div_err    = div_err_q;
   assign div_a      = div_a_q;
   assign div_b      = div_b_q;
   assign div_signed = div_signed_q;
   // The divider is held in reset for as long as the controller is.
   assign div_rst    = rst | (state_q == ST_LAUNCH);

endmodule

// File: tb/tb_muldiv_ctrl.sv
// Self-checking bench for muldiv_ctrl: directed scenarios from the feature
// list plus randomized ops against an arithmetic HI/LO reference model.
// The bench also plays the external divider.
module tb_muldiv_ctrl;

   localparam int TMO = 64;

   logic        clk = 1'b0;
   logic        rst;
   logic        op_valid;
   logic [2:0]  op_code;
   logic [31:0] op_a;
   logic [31:0] op_b;
   logic        rd_req;
   logic [31:0] hi_out;
   logic [31:0] lo_out;
   logic        busy;
   logic        stall;
   logic        div_err;
   logic [31:0] div_a;
   logic [31:0] div_b;
   logic        div_signed;
   logic        div_rst;
   logic        div_done;
   logic [31:0] div_q;
   logic [31:0] div_r;

   int checks   = 0;
   int failures = 0;

   // Reference model of the architectural state
   logic [31:0] m_hi;
   logic [31:0] m_lo;
   logic        m_err;

   always #5 clk = ~clk;

   muldiv_ctrl #(.DIV_TIMEOUT(TMO)) dut (
      .clk(clk), .rst(rst), .op_valid(op_valid), .op_code(op_code),
      .op_a(op_a), .op_b(op_b), .rd_req(rd_req),
      .hi_out(hi_out), .lo_out(lo_out), .busy(busy), .stall(stall),
      .div_err(div_err), .div_a(div_a), .div_b(div_b),
      .div_signed(div_signed), .div_rst(div_rst),
      .div_done(div_done), .div_q(div_q), .div_r(div_r)
   );

   function automatic logic [63:0] ref_mult(input logic [31:0] a, input logic [31:0] b, input bit sgn);
      longint sa;
      longint sb;
      if (sgn) begin
         sa = longint'($signed(a));
         sb = longint'($signed(b));
      end else begin
         sa = longint'({32'd0, a});
         sb = longint'({32'd0, b});
      end
      return 64'(sa * sb);
   endfunction

   // 64-bit arithmetic: truncating quotient, remainder with dividend's sign.
   task automatic ref_div(input logic [31:0] a, input logic [31:0] b, input bit sgn,
                          output logic [31:0] q, output logic [31:0] r);
      longint sa;
      longint sb;
      if (sgn) begin
         sa = longint'($signed(a));
         sb = longint'($signed(b));
      end else begin
         sa = longint'({32'd0, a});
         sb = longint'({32'd0, b});
      end
      q = 32'(sa / sb);
      r = 32'(sa % sb);
   endtask

   // Model update for ops that complete without the divider.
   task automatic model_simple(input logic [2:0] code, input logic [31:0] a, input logic [31:0] b);
      m_err = 1'b0;
      case (code)
         3'd1: {m_hi, m_lo} = ref_mult(a, b, 1'b1);
         3'd2: {m_hi, m_lo} = ref_mult(a, b, 1'b0);
         3'd3, 3'd4: begin
            m_hi = a;
            m_lo = 32'hFFFF_FFFF;
         end
         3'd5: m_hi = a;
         3'd6: m_lo = a;
         default: ;
      endcase
   endtask

   task automatic cycle();
      @(posedge clk);
      #1;
   endtask

   task automatic present(input logic [2:0] code, input logic [31:0] a, input logic [31:0] b);
      op_valid = 1'b1;
      op_code  = code;
      op_a     = a;
      op_b     = b;
      cycle();
      op_valid = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      cycle();
      cycle();
      checks++; if ({hi_out, lo_out} !== 64'd0) begin failures++; $display("FAIL reset_hilo got=%h_%h exp=0", hi_out, lo_out); end
      checks++; if ({busy, stall, div_err} !== 3'b000) begin failures++; $display("FAIL reset_flags got busy=%b stall=%b err=%b exp=000", busy, stall, div_err); end
      checks++; if ({div_a, div_b, div_signed} !== 65'd0) begin failures++; $display("FAIL reset_divops got a=%h b=%h s=%b exp=0", div_a, div_b, div_signed); end
      checks++; if (div_rst !== 1'b1) begin failures++; $display("FAIL reset_divrst got=%b exp=1", div_rst); end
      rst = 1'b0;
      cycle();
      checks++; if (div_rst !== 1'b0) begin failures++; $display("FAIL reset_release_divrst got=%b exp=0", div_rst); end
      m_hi = 32'd0; m_lo = 32'd0; m_err = 1'b0;
   endtask

   task automatic test_mult();
      logic [31:0] a;
      logic [31:0] b;
      present(3'd1, 32'hFFFF_FFFF, 32'd2);
      checks++; if ({hi_out, lo_out} !== 64'hFFFF_FFFF_FFFF_FFFE) begin failures++; $display("FAIL mult_neg got=%h_%h exp=ffffffff_fffffffe", hi_out, lo_out); end
      checks++; if (busy !== 1'b0) begin failures++; $display("FAIL mult_busy got=%b exp=0", busy); end
      present(3'd2, 32'hFFFF_FFFF, 32'd2);
      checks++; if ({hi_out, lo_out} !== 64'h0000_0001_FFFF_FFFE) begin failures++; $display("FAIL multu got=%h_%h exp=00000001_fffffffe", hi_out, lo_out); end
      checks++; if (busy !== 1'b0) begin failures++; $display("FAIL multu_busy got=%b exp=0", busy); end
      for (int i = 0; i < 6; i++) begin
         a = $urandom;
         b = $urandom;
         present(3'(1 + (i % 2)), a, b);
         model_simple(3'(1 + (i % 2)), a, b);
         checks++; if ({hi_out, lo_out} !== {m_hi, m_lo}) begin failures++; $display("FAIL mult_rand a=%h b=%h got=%h_%h exp=%h_%h", a, b, hi_out, lo_out, m_hi, m_lo); end
      end
   endtask

   task automatic test_div_zero();
      present(3'd3, 32'h1234_5678, 32'd0);
      checks++; if ({busy, div_rst} !== 2'b00) begin failures++; $display("FAIL divzero_launch got busy=%b div_rst=%b exp=00", busy, div_rst); end
      checks++; if ({hi_out, lo_out} !== 64'h1234_5678_FFFF_FFFF) begin failures++; $display("FAIL divzero_hilo got=%h_%h exp=12345678_ffffffff", hi_out, lo_out); end
      m_hi = 32'h1234_5678; m_lo = 32'hFFFF_FFFF; m_err = 1'b0;
   endtask

   task automatic test_divu();
      int bad;
      present(3'd4, 32'h5000_0000, 32'd2);
      checks++; if ({busy, div_rst} !== 2'b11) begin failures++; $display("FAIL divu_launch got busy=%b div_rst=%b exp=11", busy, div_rst); end
      checks++; if ({div_a, div_b, div_signed} !== {32'h5000_0000, 32'd2, 1'b0}) begin failures++; $display("FAIL divu_ops got a=%h b=%h s=%b", div_a, div_b, div_signed); end
      cycle();
      bad = 0;
      for (int i = 0; i < 3; i++) begin
         if (!(busy === 1'b1 && div_rst === 1'b0)) bad++;
         cycle();
      end
      checks++; if (bad != 0) begin failures++; $display("FAIL divu_wait bad_cycles=%0d exp=0", bad); end
      div_done = 1'b1; div_q = 32'h2800_0000; div_r = 32'd0;
      cycle();
      checks++; if ({hi_out, lo_out} !== 64'h0000_0000_2800_0000) begin failures++; $display("FAIL divu_result got=%h_%h exp=00000000_28000000", hi_out, lo_out); end
      checks++; if ({busy, div_err} !== 2'b00) begin failures++; $display("FAIL divu_flags got busy=%b err=%b exp=00", busy, div_err); end
      // done still high while idle must not write anything
      div_r = 32'h7777_7777;
      present(3'd5, 32'hABCD_0000, 32'd0);
      checks++; if ({hi_out, lo_out} !== 64'hABCD_0000_2800_0000) begin failures++; $display("FAIL done_ignored_idle got=%h_%h exp=abcd0000_28000000", hi_out, lo_out); end
      div_done = 1'b0;
      m_hi = 32'hABCD_0000; m_lo = 32'h2800_0000; m_err = 1'b0;
   endtask

   task automatic test_div_signed();
      logic [31:0] q;
      logic [31:0] r;
      int bad;
      present(3'd3, 32'hFFFF_FFF9, 32'd2);
      cycle();
      bad = 0;
      for (int i = 0; i < 4; i++) begin
         if ({div_a, div_b, div_signed} !== {32'hFFFF_FFF9, 32'd2, 1'b1}) bad++;
         cycle();
      end
      checks++; if (bad != 0) begin failures++; $display("FAIL div_signed_hold bad_cycles=%0d exp=0", bad); end
      ref_div(32'hFFFF_FFF9, 32'd2, 1'b1, q, r);
      div_done = 1'b1; div_q = q; div_r = r;
      cycle();
      div_done = 1'b0;
      checks++; if ({hi_out, lo_out} !== 64'hFFFF_FFFF_FFFF_FFFD) begin failures++; $display("FAIL div_signed_result got=%h_%h exp=ffffffff_fffffffd", hi_out, lo_out); end
      m_hi = 32'hFFFF_FFFF; m_lo = 32'hFFFF_FFFD; m_err = 1'b0;
   endtask

   task automatic test_timeout();
      int n;
      present(3'd5, 32'h1111_1111, 32'd0);
      present(3'd6, 32'h2222_2222, 32'd0);
      present(3'd3, 32'd7, 32'd3);
      n = 0;
      while (busy === 1'b1 && n < 200) begin
         n++;
         cycle();
      end
      checks++; if (n != 1 + TMO) begin failures++; $display("FAIL timeout_busy_cycles got=%0d exp=%0d", n, 1 + TMO); end
      checks++; if (div_err !== 1'b1) begin failures++; $display("FAIL timeout_err got=%b exp=1", div_err); end
      checks++; if ({hi_out, lo_out} !== 64'h1111_1111_2222_2222) begin failures++; $display("FAIL timeout_hilo got=%h_%h exp=11111111_22222222", hi_out, lo_out); end
      present(3'd6, 32'd5, 32'd0);
      checks++; if ({div_err, lo_out} !== {1'b0, 32'd5}) begin failures++; $display("FAIL timeout_clear got err=%b lo=%h exp err=0 lo=5", div_err, lo_out); end
      m_hi = 32'h1111_1111; m_lo = 32'd5; m_err = 1'b0;
   endtask

   task automatic test_stall_rst();
      logic [31:0] q;
      logic [31:0] r;
      int bad;
      present(3'd4, 32'h100, 32'd7);
      cycle();
      op_valid = 1'b1; op_code = 3'd5; op_a = 32'hDEAD_BEEF; op_b = 32'd0; rd_req = 1'b1;
      #1;
      bad = 0;
      for (int i = 0; i < 3; i++) begin
         if (!(stall === 1'b1 && hi_out === m_hi)) bad++;
         cycle();
      end
      checks++; if (bad != 0) begin failures++; $display("FAIL stall_hold bad_cycles=%0d exp=0", bad); end
      ref_div(32'h100, 32'd7, 1'b0, q, r);
      div_done = 1'b1; div_q = q; div_r = r;
      checks++; if (stall !== 1'b1) begin failures++; $display("FAIL stall_wb_cycle got=%b exp=1", stall); end
      cycle();
      div_done = 1'b0;
      checks++; if ({stall, busy, hi_out, lo_out} !== {2'b00, r, q}) begin failures++; $display("FAIL stall_release got stall=%b busy=%b hi=%h lo=%h exp 0 0 %h %h", stall, busy, hi_out, lo_out, r, q); end
      cycle();
      op_valid = 1'b0; rd_req = 1'b0;
      checks++; if (hi_out !== 32'hDEAD_BEEF) begin failures++; $display("FAIL stall_mthi_late got=%h exp=deadbeef", hi_out); end
      // reset in the middle of a divide, with done high that very cycle
      present(3'd3, 32'd50, 32'd5);
      cycle();
      div_done = 1'b1; div_q = 32'hAAAA_AAAA; div_r = 32'h5555_5555; rst = 1'b1;
      #1;
      checks++; if (div_rst !== 1'b1) begin failures++; $display("FAIL rst_divrst got=%b exp=1", div_rst); end
      cycle();
      checks++; if ({busy, div_err, hi_out, lo_out} !== 66'd0) begin failures++; $display("FAIL rst_mid_wait got busy=%b err=%b hi=%h lo=%h exp all 0", busy, div_err, hi_out, lo_out); end
      rst = 1'b0; div_done = 1'b0;
      cycle();
      checks++; if ({busy, div_rst} !== 2'b00) begin failures++; $display("FAIL rst_after got busy=%b div_rst=%b exp=00", busy, div_rst); end
      m_hi = 32'd0; m_lo = 32'd0; m_err = 1'b0;
   endtask

   task automatic test_back_to_back();
      logic [31:0] q;
      logic [31:0] r;
      logic [31:0] a;
      logic [31:0] b;
      present(3'd4, 32'd1000, 32'd10);
      cycle();
      ref_div(32'd1000, 32'd10, 1'b0, q, r);
      div_done = 1'b1; div_q = q; div_r = r;
      cycle();
      div_done = 1'b0;
      a = $urandom; b = $urandom;
      present(3'd2, a, b);
      model_simple(3'd2, a, b);
      checks++; if ({hi_out, lo_out, busy} !== {m_hi, m_lo, 1'b0}) begin failures++; $display("FAIL back_to_back got=%h_%h busy=%b exp=%h_%h", hi_out, lo_out, busy, m_hi, m_lo); end
   endtask

   task automatic test_random();
      logic [2:0]  code;
      logic [31:0] a;
      logic [31:0] b;
      logic [31:0] q;
      logic [31:0] r;
      bit          sgn;
      bit          tmo;
      int          lat;
      int          bad;
      for (int it = 0; it < 40; it++) begin
         code = 3'($urandom_range(0, 7));
         a = $urandom;
         b = $urandom;
         if ($urandom_range(0, 5) == 0) b = 32'd0;
         if ((code == 3'd3 || code == 3'd4) && b != 32'd0) begin
            sgn = (code == 3'd3);
            present(code, a, b);
            checks++; if ({div_a, div_b, div_signed} !== {a, b, sgn}) begin failures++; $display("FAIL rand_latch it=%0d got a=%h b=%h s=%b exp %h %h %b", it, div_a, div_b, div_signed, a, b, sgn); end
            cycle();
            tmo = ($urandom_range(0, 9) == 0);
            lat = tmo ? TMO : $urandom_range(0, 6);
            bad = 0;
            for (int i = 0; i < lat; i++) begin
               if (busy !== 1'b1) bad++;
               cycle();
            end
            if (tmo) begin
               m_err = 1'b1;
            end else begin
               ref_div(a, b, sgn, q, r);
               div_done = 1'b1; div_q = q; div_r = r;
               cycle();
               div_done = 1'b0;
               m_hi = r; m_lo = q; m_err = 1'b0;
            end
            checks++; if (bad != 0) begin failures++; $display("FAIL rand_busy it=%0d bad_cycles=%0d exp=0", it, bad); end
         end else begin
            present(code, a, b);
            model_simple(code, a, b);
         end
         checks++; if ({hi_out, lo_out, div_err, busy} !== {m_hi, m_lo, m_err, 1'b0}) begin
            failures++;
            $display("FAIL rand_state it=%0d op=%0d a=%h b=%h got=%h_%h err=%b busy=%b exp=%h_%h err=%b busy=0",
                     it, code, a, b, hi_out, lo_out, div_err, busy, m_hi, m_lo, m_err);
         end
      end
   endtask

   initial begin
      rst = 1'b1; op_valid = 1'b0; op_code = 3'd0; op_a = 32'd0; op_b = 32'd0;
      rd_req = 1'b0; div_done = 1'b0; div_q = 32'd0; div_r = 32'd0;
      test_reset();
      test_mult();
      test_div_zero();
      test_divu();
      test_div_signed();
      test_timeout();
      test_stall_rst();
      test_back_to_back();
      test_random();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #400000;
      $display("FAIL watchdog time limit reached checks=%0d", checks);
      $fatal(1);
   end

endmodule

// File: doc/muldiv_ctrl.md
# muldiv_ctrl

Controller for the MIPS HI/LO multiply/divide unit. Decodes MULT/MULTU/DIV/DIVU/MTHI/MTLO requests from the execute stage and owns the architectural HI and LO registers. Computes products in one cycle and sequences the external iterative divider: latches operands, pulses its reset/load, waits for completion and writes back the quotient and remainder. Stalls the pipeline while a divide is in flight.

## Interface
- DIV_TIMEOUT, 64: max WAIT cycles before a divide is aborted.
- clk  in  1  rising-edge clock.
- rst  in  1  synchronous, active-high reset.
- op_valid  in  1  request strobe; accepted only when busy=0.
- op_code  in  3  001 MULT, 010 MULTU, 011 DIV, 100 DIVU, 101 MTHI, 110 MTLO; others are a no-op.
- op_a  in  32  rs operand (dividend, multiplicand, MT source).
- op_b  in  32  rt operand (divisor, multiplier).
- rd_req  in  1  MFHI/MFLO in execute.
- hi_out  out  32  HI register.
- lo_out  out  32  LO register.
- busy  out  1  divide in flight.
- stall  out  1  busy & (op_valid | rd_req).
- div_err  out  1  last divide timed out; sticky until the next accepted op.
- div_a  out  32  latched dividend to divider.
- div_b  out  32  latched divisor to divider.
- div_signed  out  1  latched signdiv to divider.
- div_rst  out  1  divider reset/load pulse.
- div_done  in  1  divider completion; level, held until next div_rst.
- div_q  in  32  divider quotient.
- div_r  in  32  divider remainder.

## Operation
- States: IDLE, LAUNCH, WAIT.
- Accept means op_valid & !busy in IDLE.
- MULT: {HI,LO} <= signed 64-bit op_a*op_b.
- MULTU: {HI,LO} <= unsigned 64-bit op_a*op_b.
- MULT and MULTU stay in IDLE.
- MTHI: HI <= op_a. MTLO: LO <= op_a. Both stay in IDLE.
- DIV/DIVU with op_b != 0:
  - Latch div_a=op_a, div_b=op_b, div_signed=(DIV).
  - Go to LAUNCH, then WAIT.
- DIV/DIVU with op_b == 0:
  - Divider is not launched.
  - HI <= op_a, LO <= 32'hFFFFFFFF.
  - Stay in IDLE.
- LAUNCH: div_rst=1 for exactly one cycle, then WAIT; the wait counter clears.
- WAIT:
  - div_done=1 -> LO <= div_q, HI <= div_r, go to IDLE.
  - Counter reaching DIV_TIMEOUT first -> HI/LO unchanged, div_err <= 1, go to IDLE.
- div_done is ignored outside WAIT.
- div_a/div_b/div_signed are held stable from LAUNCH through WAIT exit.
- busy = (state != IDLE). Requests presented while busy are not accepted; the pipeline holds them via stall.
- Signed divide follows MIPS truncation: quotient rounds toward zero, remainder takes the dividend's sign (produced by the divider).
- div_err clears on any accepted op.

## Timing
- Reset values:
  - state=IDLE, hi_out=lo_out=0, busy=0, stall=0, div_err=0.
  - div_a=div_b=0, div_signed=0.
  - div_rst=1 while rst is high (div_rst = rst | LAUNCH).
- MULT/MULTU/MTHI/MTLO/div-by-zero accepted at edge T: result visible on hi_out/lo_out after edge T+1; busy never rises.
- DIV accepted at T:
  - After T+1, busy=1 and div_rst=1 (LAUNCH).
  - After T+2, state is WAIT and div_rst=0.
  - div_done first seen high in cycle D: HI/LO updated and busy=0 after edge D+1.
- Back-to-back: a new op may be accepted in the first cycle busy=0.
- Timeout: abort on the DIV_TIMEOUT-th WAIT cycle without done.
- rst mid-divide, any state: next edge forces IDLE and clears HI/LO and div_err. The divider is reset through div_rst. No writeback occurs even if div_done is high that cycle.
- rd_req during busy holds stall=1 until the cycle HI/LO are written. rd_req in the writeback cycle sees stall=0 next cycle with updated values.

## Test plan
- DIVU a=0x50000000, b=2 -> one div_rst pulse; after div_done, LO=0x28000000, HI=0, busy=0, div_err=0.
- DIV a=0xFFFFFFF9 (-7), b=2 -> LO=0xFFFFFFFD, HI=0xFFFFFFFF; div_signed=1 throughout WAIT.
- MULT a=0xFFFFFFFF, b=2 -> HI=0xFFFFFFFF, LO=0xFFFFFFFE one cycle later. MULTU with the same operands -> HI=0x00000001, LO=0xFFFFFFFE. busy never asserted.
- DIV b=0, a=0x12345678 -> no div_rst pulse; HI=0x12345678, LO=0xFFFFFFFF next cycle.
- div_done tied low, DIV_TIMEOUT=64 -> busy high for 1+64 cycles, then busy=0, div_err=1, HI/LO unchanged. A following MTLO 0x5 clears div_err and sets LO=5.
- DIVU in WAIT with op_valid (MTHI) and rd_req held -> stall=1, MTHI not applied until busy drops. rst asserted mid-WAIT -> IDLE next edge, HI=LO=0, div_rst high during rst.
